// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Accepts one aligned word load or store while idle, holds the pipeline with
// StallMem for LATENCY wait cycles, performs the access, then pulses RespValid
// for one cycle. Misaligned requests are dropped and flagged with MisalignErr.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqM,
    input  logic        WEM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WDM,
    output logic        StallMem,
    output logic        RespValid,
    output logic [31:0] RDM,
    output logic        MisalignErr
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wd;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_aligned;
    logic            w_accept;
    logic            w_access;
    logic [AW-1:0]   w_idx;
    logic            w_unused_addr;

    // Word index drops the byte offset; bits above the array size wrap.
    assign w_idx         = AddrM[AW+1:2];
    assign w_unused_addr = ^AddrM[31:AW+2];
    assign w_aligned     = (AddrM[1:0] == 2'b00);

    // A request is taken only from IDLE; the access fires on the last wait cycle.
    assign w_accept = (r_state == S_IDLE) && ReqM && w_aligned;
    assign w_access = (r_state == S_WAIT) && (r_cnt == '0);

    // NOTE: StallMem and MisalignErr must react in the request cycle itself, so
    // they are decoded combinationally; gating with rst keeps them low during reset.
    assign StallMem    = rst && (w_accept || (r_state == S_WAIT));
    assign MisalignErr = rst && (r_state == S_IDLE) && ReqM && !w_aligned;
    assign RespValid   = (r_state == S_DONE);

    // Control FSM: latch the request, count down the latency, complete, report.
    // NOTE: every register here uses non-blocking assignment so all state moves
    // together on the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wd    <= '0;
            RDM     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= WEM;
                        r_idx   <= w_idx;
                        r_wd    <= WDM;
                        r_cnt   <= CW'(LATENCY - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (!r_we) begin
                            RDM <= r_mem[r_idx];
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array write port; a store lands on the completing edge only.
    // NOTE: the array is deliberately not reset, so it maps onto plain RAM;
    // a reset during WAIT forces IDLE, which withholds w_access and drops the store.
    always_ff @(posedge clk) begin
        if (w_access && r_we) begin
            r_mem[r_idx] <= r_wd;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a driver issues directed and random
// requests and pushes the expected response into a scoreboard; a monitor pops
// and compares whenever RespValid is seen. A second instance runs LATENCY=1.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        ReqM, WEM;
    logic [31:0] AddrM, WDM;
    logic        StallMem, RespValid, MisalignErr;
    logic [31:0] RDM;

    logic        req1, we1;
    logic [31:0] addr1, wd1;
    logic        stall1, resp1, mis1;
    logic [31:0] rdm1;

    typedef struct {
        logic [31:0] rdm;
        int          t_issue;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] rdm_m;
    int          cyc;
    int          n_vec;
    int          n_err;
    bit          prev_resp;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .ReqM(ReqM), .WEM(WEM), .AddrM(AddrM), .WDM(WDM),
        .StallMem(StallMem), .RespValid(RespValid), .RDM(RDM), .MisalignErr(MisalignErr)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .ReqM(req1), .WEM(we1), .AddrM(addr1), .WDM(wd1),
        .StallMem(stall1), .RespValid(resp1), .RDM(rdm1), .MisalignErr(mis1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    // Monitor: compares every completion against the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_resp = 1'b0;
        end else begin
            check("stall_resp_exclusive", {31'd0, StallMem & RespValid}, 32'd0);
            if (RespValid) begin
                check("resp_back_to_back", {31'd0, prev_resp}, 32'd0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_resp: RespValid=1 with nothing outstanding, required 0");
                end else begin
                    e = sb.pop_front();
                    check("rdm", RDM, e.rdm);
                    check("resp_cycle", cyc - e.t_issue, LAT + 1);
                end
            end
            prev_resp = RespValid;
        end
    end

    // One request on the main instance; garbage=1 scrambles AddrM/WDM after acceptance.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input bit garbage);
        int   stalls;
        exp_t e;
        int   ix;
        @(negedge clk);
        check("idle_stall", {31'd0, StallMem}, 32'd0);
        check("idle_resp", {31'd0, RespValid}, 32'd0);
        check("idle_misalign", {31'd0, MisalignErr}, 32'd0);
        @(posedge clk); #1;
        ReqM = 1'b1; WEM = we; AddrM = addr; WDM = wd;
        if (addr[1:0] != 2'b00) begin
            @(negedge clk);
            check("misalign_err", {31'd0, MisalignErr}, 32'd1);
            check("misalign_stall", {31'd0, StallMem}, 32'd0);
            check("misalign_rdm", RDM, rdm_m);
            @(posedge clk); #1;
            ReqM = 1'b0;
        end else begin
            ix = idx_of(addr);
            if (we) mem_m[ix] = wd;
            else    rdm_m = mem_m[ix];
            e.rdm     = rdm_m;
            e.t_issue = cyc;
            sb.push_back(e);
            stalls = 0;
            @(negedge clk);
            while (StallMem && stalls < 50) begin
                stalls++;
                @(posedge clk); #1;
                if (garbage) begin
                    AddrM = $urandom;
                    WDM   = $urandom;
                end
                @(negedge clk);
            end
            check("stall_cycles", stalls, LAT + 1);
            @(posedge clk); #1;
            ReqM = 1'b0; AddrM = $urandom; WDM = $urandom;
        end
    endtask

    // One request on the LATENCY=1 instance with cycle-exact checks.
    task automatic l1_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_rdm);
        @(posedge clk); #1;
        req1 = 1'b1; we1 = we; addr1 = addr; wd1 = wd;
        @(negedge clk);
        check("l1_stall_c0", {31'd0, stall1}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_stall_c1", {31'd0, stall1}, 32'd1);
        check("l1_resp_c1", {31'd0, resp1}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_stall_c2", {31'd0, stall1}, 32'd0);
        check("l1_resp_c2", {31'd0, resp1}, 32'd1);
        check("l1_rdm", rdm1, exp_rdm);
        @(posedge clk); #1;
        req1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; n_vec = 0; n_err = 0; prev_resp = 1'b0; rdm_m = 32'd0;
        rst = 1'b0;
        ReqM = 1'b0; WEM = 1'b0; AddrM = 32'd0; WDM = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, StallMem}, 32'd0);
        check("rst_resp", {31'd0, RespValid}, 32'd0);
        check("rst_misalign", {31'd0, MisalignErr}, 32'd0);
        check("rst_rdm", RDM, 32'd0);
        #1 rst = 1'b1;

        // Give the low words known contents so every later load has a defined answer.
        for (int k = 0; k < 32; k++) do_req(1'b1, 32'(k) << 2, $urandom, 1'b0);

        // Store then load of the same word.
        do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 32'h0000_0010, 32'd0, 1'b0);

        // Port changes after acceptance must not affect the access.
        do_req(1'b0, 32'h0000_0014, 32'h0BAD_0BAD, 1'b1);
        do_req(1'b1, 32'h0000_0018, 32'h1357_9BDF, 1'b1);
        do_req(1'b0, 32'h0000_0018, 32'd0, 1'b0);
        do_req(1'b0, 32'h0000_0014, 32'd0, 1'b0);

        // Misaligned request is dropped.
        do_req(1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 1'b0);
        do_req(1'b0, 32'h0000_0020, 32'd0, 1'b0);

        // Reset mid-WAIT with a store pending and ReqM still high.
        @(posedge clk); #1;
        ReqM = 1'b1; WEM = 1'b1; AddrM = 32'h0000_000C; WDM = 32'h5555_AAAA;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midrst_stall", {31'd0, StallMem}, 32'd0);
        check("midrst_resp", {31'd0, RespValid}, 32'd0);
        check("midrst_misalign", {31'd0, MisalignErr}, 32'd0);
        check("midrst_rdm", RDM, 32'd0);
        ReqM = 1'b0;
        sb.delete();
        rdm_m = 32'd0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        do_req(1'b0, 32'h0000_000C, 32'd0, 1'b0);

        // Store discarded by reset during WAIT.
        @(posedge clk); #1;
        ReqM = 1'b1; WEM = 1'b1; AddrM = 32'h0000_0020; WDM = 32'h0000_1234;
        @(posedge clk); #2;
        rst = 1'b0;
        ReqM = 1'b0;
        sb.delete();
        rdm_m = 32'd0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        do_req(1'b0, 32'h0000_0020, 32'd0, 1'b0);

        // Address wrap past the array size.
        do_req(1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 1'b0);
        do_req(1'b0, 32'h0000_0000, 32'd0, 1'b0);

        // Randomized traffic over the known words, with aliased upper bits.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = (32'($urandom) << 12) | (32'($urandom_range(0, 31)) << 2);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);

        // LATENCY=1 instance: completion in the third cycle, wrap addressing.
        l1_access(1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 32'd0);
        l1_access(1'b0, 32'h0000_0000, 32'd0, 32'hA5A5_A5A5);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
